// File: rtl/ofmap_drain.sv
// -----------------------------------------------------------------------------
// ofmap_drain
//   Streams a contiguous block of words out of the output-feature-map SRAM.
//   A start request latches a base word address and a word count; the block
//   issues single-cycle-latency SRAM reads into a small output FIFO, never
//   letting buffered words plus reads in flight exceed the FIFO depth, and
//   presents the FIFO head on a valid/ready stream. m_last_o flags the final
//   word of the job; finish_o pulses once when the final word has been taken.
//
// Parameters
//   ADDR_W     : SRAM word-address width (address arithmetic wraps at 2^ADDR_W)
//   DATA_W     : SRAM word / stream data width
//   FIFO_DEPTH : output buffer entries (power of two, >= 2)
//
// Ports
//   clk, rstn              : clock, asynchronous active-low reset
//   start_i                : one-cycle drain request (ignored while busy_o)
//   base_addr_i, len_i     : first word address and word count, sampled on start
//   busy_o                 : high from an accepted start until the finish pulse
//   finish_o               : one-cycle completion pulse
//   mem_cs_o, mem_oe_o     : SRAM chip select / read enable (read strobe)
//   mem_addr_o             : SRAM word address
//   mem_rdata_i            : SRAM read data, valid one cycle after the read
//   m_valid_o, m_data_o,
//   m_last_o, m_ready_i    : downstream stream
//
// Configuration
//   OFMAP_DRAIN_RELU_EN : when defined, words are treated as signed and any
//                         negative word is replaced by zero before buffering.
// -----------------------------------------------------------------------------
module ofmap_drain #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              finish_o,
  output logic              mem_cs_o,
  output logic              mem_oe_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] base_q, len_q;
  logic [ADDR_W-1:0] issued_q;   // reads issued in this job
  logic [ADDR_W-1:0] popped_q;   // words handed downstream in this job
  logic              in_flight_q; // a read was issued last cycle

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              accept, do_read, push, pop, last_head;
  logic [DATA_W-1:0] push_data;

  assign accept    = (state == ST_IDLE) && start_i;
  assign m_valid_o = (count_q != '0);
  assign pop       = m_valid_o && m_ready_i;
  // SRAM data arrives exactly one cycle after its read, so the in-flight flag
  // doubles as the FIFO push strobe.
  assign push      = in_flight_q;
  assign last_head = (popped_q == len_q - 1'b1);

  // Reservation counts in-flight reads as occupied so a push can never find
  // the FIFO full, even if the consumer stalls.
  assign do_read = (state == ST_READ) && (issued_q != len_q) &&
                   ((count_q + CNT_W'(in_flight_q)) < CNT_W'(FIFO_DEPTH));

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i) state_nxt = (len_i == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (issued_q == len_q) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && last_head) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    push_data = mem_rdata_i;
`ifdef OFMAP_DRAIN_RELU_EN
    if (mem_rdata_i[DATA_W-1]) push_data = '0;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      in_flight_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
    end else begin
      state       <= state_nxt;
      in_flight_q <= do_read;
      if (accept) begin
        base_q   <= base_addr_i;
        len_q    <= len_i;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (do_read) issued_q <= issued_q + 1'b1;
        if (pop)     popped_q <= popped_q + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the cleared count and
  // pointers make stale entries unreachable, and the output data is gated.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  assign busy_o     = (state != ST_IDLE);
  assign finish_o   = (state == ST_DONE);
  assign mem_cs_o   = do_read;
  assign mem_oe_o   = do_read;
  assign mem_addr_o = do_read ? (base_q + issued_q) : '0;
  assign m_data_o   = m_valid_o ? fifo_mem[rd_ptr] : '0;
  assign m_last_o   = m_valid_o && last_head;

endmodule

// File: tb/tb_ofmap_drain.sv
// -----------------------------------------------------------------------------
// tb_ofmap_drain
//   Self-checking bench for ofmap_drain. A table of jobs is run in a loop;
//   each job pushes its expected beats (address order, last flag) onto a
//   scoreboard queue that a negedge monitor pops on every stream handshake.
//   The monitor also checks data hold under backpressure, the read-window
//   limit and the read address sequence. A hand-written sequence covers a
//   reset in the middle of a job. Honours OFMAP_DRAIN_RELU_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_ofmap_drain;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i, len_i;
  logic              busy_o, finish_o, mem_cs_o, mem_oe_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              m_valid_o, m_last_o, m_ready_i;
  logic [DATA_W-1:0] m_data_o;

  ofmap_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .finish_o(finish_o), .mem_cs_o(mem_cs_o),
    .mem_oe_o(mem_oe_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    bit                rnd_ready;
    int                mode;       // SRAM contents pattern
    bit                spurious;   // pulse start_i while busy
    int                exp_first;  // cycle of first m_valid_o after start cycle, -1 = unchecked
    int                exp_finish; // cycle of finish_o after start cycle, -1 = unchecked
  } job_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  int n_cmp = 0;
  int n_err = 0;
  int mem_mode = 0;
  beat_t             sb[$];
  logic [ADDR_W-1:0] addr_q[$];
  int cs_tot = 0, beat_tot = 0, fin_tot = 0, iss_tot = 0, pop_tot = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    case (mem_mode)
      0:       return {15'd0, a};
      1:       return {a[7:0], ~a[15:8], a[16:1]};
      default: return 32'hFFFF_FFF0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = mem_word(a);
`ifdef OFMAP_DRAIN_RELU_EN
    if (w[DATA_W-1]) w = '0;
`endif
    return w;
  endfunction

  // SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_cs_o && mem_oe_o) mem_rdata_i <= mem_word(mem_addr_o);
  end

  // Stream / SRAM-side monitor.
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  beat_t             e;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      iss_tot = 0;
      pop_tot = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(m_valid_o), 64'd1);
        check("hold_data", 64'(m_data_o), 64'(stall_data));
      end
      if (mem_cs_o) begin
        check("oe_with_cs", 64'(mem_oe_o), 64'd1);
        check("read_window", 64'((iss_tot - pop_tot) < FIFO_DEPTH), 64'd1);
        addr_q.push_back(mem_addr_o);
        iss_tot++;
        cs_tot++;
      end
      if (m_valid_o && m_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(m_data_o), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("beat_data", 64'(m_data_o), 64'(e.data));
          check("beat_last", 64'(m_last_o), 64'(e.last));
        end
        pop_tot++;
        beat_tot++;
      end
      if (finish_o) fin_tot++;
      stall_q    = m_valid_o && !m_ready_i;
      stall_data = m_data_o;
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, {9'd0, busy_o, finish_o, mem_cs_o, mem_oe_o, mem_addr_o,
                 m_valid_o, m_data_o, m_last_o}, 64'd0);
  endtask

  task automatic run_job(input job_t j);
    int first_k, fin_k, cs0, beat0;
    logic [ADDR_W-1:0] a;
    mem_mode = j.mode;
    for (int i = 0; i < int'(j.len); i++) begin
      a = j.base + ADDR_W'(i);
      sb.push_back('{data: exp_word(a), last: (i == int'(j.len) - 1)});
    end
    addr_q.delete();
    cs0 = cs_tot;
    beat0 = beat_tot;
    first_k = -1;
    fin_k = -1;
    @(posedge clk); #1;
    start_i = 1'b1;
    base_addr_i = j.base;
    len_i = j.len;
    m_ready_i = j.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_in_start_cycle", 64'(busy_o), 64'd0);
      if (k == 1) check("busy_after_start", 64'(busy_o), 64'd1);
      if (m_valid_o && first_k < 0) first_k = k;
      if (finish_o) begin
        fin_k = k;
        break;
      end
      @(posedge clk); #1;
      // Scramble the job inputs after the start cycle; a second start while
      // busy must be ignored.
      start_i = j.spurious && (k == 1);
      base_addr_i = 17'h0ABCD;
      len_i = 17'd3;
      m_ready_i = j.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start_i = 1'b0;
    check("finish_seen", 64'(fin_k >= 0), 64'd1);
    if (j.exp_finish >= 0) check("finish_latency", 64'(fin_k), 64'(j.exp_finish));
    if (j.exp_first >= 0) check("first_valid_latency", 64'(first_k), 64'(j.exp_first));
    if (j.len == '0) check("no_valid_len0", 64'(first_k), 64'(-1));
    @(posedge clk); #1;
    m_ready_i = 1'b1;
    @(negedge clk);
    check("busy_after_done", 64'(busy_o), 64'd0);
    check("finish_one_cycle", 64'(finish_o), 64'd0);
    check("read_count", 64'(cs_tot - cs0), 64'(j.len));
    check("beat_count", 64'(beat_tot - beat0), 64'(j.len));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    for (int i = 0; i < addr_q.size(); i++) begin
      a = j.base + ADDR_W'(i);
      check("read_addr", 64'(addr_q[i]), 64'(a));
    end
  endtask

  job_t jobs[6];
  job_t rj;

  initial begin
    int b0, f0;
    jobs[0] = '{17'h00010, 17'd8,  1'b0, 0, 1'b0, 3, 11};
    jobs[1] = '{17'h00020, 17'd0,  1'b0, 0, 1'b0, -1, 1};
    jobs[2] = '{17'h1FFFE, 17'd4,  1'b0, 0, 1'b0, 3, 7};
    jobs[3] = '{17'h00100, 17'd16, 1'b1, 1, 1'b0, -1, -1};
    jobs[4] = '{17'h00200, 17'd1,  1'b0, 2, 1'b1, 3, 4};
    jobs[5] = '{17'h1FFF0, 17'd24, 1'b1, 1, 1'b1, -1, -1};

    rstn = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    len_i = '0;
    m_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rstn = 1'b1;

    for (int n = 0; n < 6; n++) run_job(jobs[n]);

    // Reset in the middle of a len=10 job, after three beats.
    mem_mode = 0;
    for (int i = 0; i < 10; i++)
      sb.push_back('{data: exp_word(17'h00080 + 17'(i)), last: (i == 9)});
    b0 = beat_tot;
    @(posedge clk); #1;
    start_i = 1'b1;
    base_addr_i = 17'h00080;
    len_i = 17'd10;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (beat_tot - b0 >= 3) break;
    end
    check("beats_before_reset", 64'(beat_tot - b0 >= 3), 64'd1);
    f0 = fin_tot;
    #2 rstn = 1'b0;
    #1 check_reset_outputs("outputs_at_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("outputs_in_reset");
    #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("no_finish_after_reset", 64'(fin_tot - f0), 64'd0);
    check("idle_after_reset", {62'd0, busy_o, m_valid_o}, 64'd0);
    rj = '{17'h00040, 17'd2, 1'b0, 0, 1'b0, 3, 5};
    run_job(rj);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
